// File: rtl/char_contact_damage_pkg.sv
// Shared definitions for the character contact-damage block.
// Holds the FSM state type, default gameplay constants and geometry widths.
package char_contact_damage_pkg;

  localparam int unsigned CD_MAX_HP      = 10;  // HP at reset and on each new game
  localparam int unsigned CD_CONTACT_DMG = 2;   // HP removed per contact hit
  localparam int unsigned CD_IFRAMES     = 60;  // invulnerability length in frame ticks
  localparam int unsigned CD_HP_W        = 4;   // width of char_hp
  localparam int unsigned CD_COORD_W     = 12;  // pixel coordinate / size width
  localparam int unsigned CD_IFR_W       = 7;   // holds IFRAMES up to 127

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIVE  = 2'd1,
    ST_INVULN = 2'd2,
    ST_DEAD   = 2'd3
  } cd_state_e;

endpackage

// File: rtl/char_contact_damage_aabb_overlap.sv
// aabb_overlap: combinational axis-aligned box test plus centre compare.
// Reusable for any box-versus-box hit (character or projectile vs boss).
//   a_* / b_*  : left edge, top edge, width, height of boxes A and B
//   overlap    : interiors intersect (touching edges and empty boxes do not count)
//   a_left     : centre of A is strictly left of centre of B
module aabb_overlap
  import char_contact_damage_pkg::*;
#(
  parameter int unsigned W = CD_COORD_W
) (
  input  logic [W-1:0] a_x,
  input  logic [W-1:0] a_y,
  input  logic [W-1:0] a_lng,
  input  logic [W-1:0] a_hgt,
  input  logic [W-1:0] b_x,
  input  logic [W-1:0] b_y,
  input  logic [W-1:0] b_lng,
  input  logic [W-1:0] b_hgt,
  output logic         overlap,
  output logic         a_left
);

  // One extra bit so edge sums never wrap.
  logic [W:0] a_xe, a_ye, b_xe, b_ye;
  logic [W:0] a_cx, b_cx;
  logic       non_empty;

  assign a_xe = {1'b0, a_x} + {1'b0, a_lng};
  assign a_ye = {1'b0, a_y} + {1'b0, a_hgt};
  assign b_xe = {1'b0, b_x} + {1'b0, b_lng};
  assign b_ye = {1'b0, b_y} + {1'b0, b_hgt};

  // A zero-size box inside the other would otherwise pass the strict compares.
  assign non_empty = (|a_lng) && (|a_hgt) && (|b_lng) && (|b_hgt);

  assign overlap = non_empty
                && ({1'b0, a_x} < b_xe) && ({1'b0, b_x} < a_xe)
                && ({1'b0, a_y} < b_ye) && ({1'b0, b_y} < a_ye);

  assign a_cx   = {1'b0, a_x} + {2'b00, a_lng[W-1:1]};
  assign b_cx   = {1'b0, b_x} + {2'b00, b_lng[W-1:1]};
  assign a_left = (a_cx < b_cx);  // equal centres push right

endmodule

// File: rtl/char_contact_damage.sv
// char_contact_damage: per-frame character-vs-boss contact damage.
// Tests the character box against the boss box, deducts HP on contact,
// opens an invulnerability window and latches the knockback direction.
//   clk, rst        : system clock, async active-low reset
//   frame_tick      : one-clk pulse per frame
//   game_active     : low forces IDLE with full HP
//   char_*, boss_*  : boxes (left, top, width, height); boss_hp==0 disables contact
//   char_hp         : player HP
//   char_hit        : one-clk pulse per damage event (cycle after the tick)
//   char_invuln     : invulnerability window active
//   char_dead       : HP exhausted, sticky while the game runs
//   knock_left      : direction at the last hit, 1 = push character left
module char_contact_damage
  import char_contact_damage_pkg::*;
#(
  parameter int unsigned MAX_HP      = CD_MAX_HP,
  parameter int unsigned CONTACT_DMG = CD_CONTACT_DMG,
  parameter int unsigned IFRAMES     = CD_IFRAMES,
  parameter int unsigned HP_W        = CD_HP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            game_active,
  input  logic [11:0]     char_x,
  input  logic [11:0]     char_y,
  input  logic [11:0]     char_lng,
  input  logic [11:0]     char_hgt,
  input  logic [11:0]     boss_x,
  input  logic [11:0]     boss_y,
  input  logic [11:0]     boss_lng,
  input  logic [11:0]     boss_hgt,
  input  logic [6:0]      boss_hp,
  output logic [HP_W-1:0] char_hp,
  output logic            char_hit,
  output logic            char_invuln,
  output logic            char_dead,
  output logic            knock_left
);

  localparam logic [HP_W-1:0]     HP_FULL  = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0]     HP_DMG   = HP_W'(CONTACT_DMG);
  localparam logic [CD_IFR_W-1:0] IFR_INIT = CD_IFR_W'(IFRAMES);
  localparam logic [CD_IFR_W-1:0] IFR_ONE  = CD_IFR_W'(1);

  cd_state_e           state_q, state_d;
  logic [HP_W-1:0]     hp_q, hp_d, hp_after;
  logic [CD_IFR_W-1:0] ifr_q, ifr_d;
  logic                hit_q, hit_d;
  logic                knock_q, knock_d;
  logic                overlap_q;
  logic                ovl_c, left_c;

  aabb_overlap #(.W(12)) u_aabb (
    .a_x     (char_x),
    .a_y     (char_y),
    .a_lng   (char_lng),
    .a_hgt   (char_hgt),
    .b_x     (boss_x),
    .b_y     (boss_y),
    .b_lng   (boss_lng),
    .b_hgt   (boss_hgt),
    .overlap (ovl_c),
    .a_left  (left_c)
  );

  // Saturating HP deduction.
  assign hp_after = (hp_q > HP_DMG) ? (hp_q - HP_DMG) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      hp_q      <= HP_FULL;
      ifr_q     <= '0;
      hit_q     <= 1'b0;
      knock_q   <= 1'b0;
      overlap_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      ifr_q     <= ifr_d;
      hit_q     <= hit_d;
      knock_q   <= knock_d;
      // Dead boss deals no contact damage.
      overlap_q <= ovl_c && (boss_hp != 7'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    ifr_d   = ifr_q;
    hit_d   = 1'b0;
    knock_d = knock_q;
    if (!game_active) begin
      // Leaving the game wins over any same-cycle hit.
      state_d = ST_IDLE;
      hp_d    = HP_FULL;
      ifr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ALIVE;
          hp_d    = HP_FULL;
        end
        ST_ALIVE: begin
          if (frame_tick && overlap_q) begin
            hit_d   = 1'b1;
            knock_d = left_c;
            hp_d    = hp_after;
            if (hp_after == '0) begin
              state_d = ST_DEAD;
            end else begin
              state_d = ST_INVULN;
              ifr_d   = IFR_INIT;
            end
          end
        end
        ST_INVULN: begin
          // The tick that ends the window never hits; earliest hit is next tick.
          if (frame_tick) begin
            if (ifr_q == IFR_ONE) begin
              state_d = ST_ALIVE;
              ifr_d   = '0;
            end else begin
              ifr_d = ifr_q - IFR_ONE;
            end
          end
        end
        ST_DEAD: begin
          hp_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          hp_d    = HP_FULL;
          ifr_d   = '0;
        end
      endcase
    end
  end

  assign char_hp     = hp_q;
  assign char_hit    = hit_q;
  assign knock_left  = knock_q;
  assign char_invuln = (state_q == ST_INVULN);
  assign char_dead   = (state_q == ST_DEAD);

endmodule
